mux_arb_nto1: RTL and testbench
===============================

# mux_arb_nto1

Parametrised N-to-1 bus multiplexer with a registered output stage and valid/ready handshaking on every channel. It generalises the sCPU's fixed 2:1 8-bit data muxes to CHANNELS sources of WIDTH bits. Selection is either fixed (external select, as in the datapath muxes) or round-robin arbitrated. It sits wherever several producers (register file, ALU, immediate, I/O) feed one consumer that may stall.

## Interface
- WIDTH, 8, data width per channel (>= 1)
- CHANNELS, 4, number of input channels (2..16)
- MODE, 0, 0 = fixed select from `sel`; 1 = round-robin among valid channels
- SELW, $clog2(CHANNELS), width of `sel` and `out_chan` (derived; do not override)

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  channel i has data
- in_ready  out  CHANNELS  channel i's beat is accepted this cycle
- sel  in  SELW  channel select, used only when MODE = 0
- out_data  out  WIDTH  registered selected data
- out_chan  out  SELW  index of the channel that supplied out_data
- out_valid  out  1  out_data/out_chan hold a beat
- out_ready  in  1  consumer accepts the beat

## Operation
- Output register holds at most one beat; it is the only data storage.
- `load = ~out_valid | out_ready` (slot empty, or draining this cycle).
- Grant, combinational, at most one bit set:
  - MODE 0: grant[sel] = in_valid[sel]. If sel >= CHANNELS, no grant. This replaces the old mux's default-to-zero arm; out_data is not cleared.
  - MODE 1: search from (last + 1) mod CHANNELS upward with wrap. Grant the first channel with in_valid set. `last` is the index of the most recently accepted channel.
- in_ready[i] = grant[i] & load. in_ready depends combinationally on in_valid, sel and out_ready. Producers must not make in_valid depend on in_ready.
- Accept (any in_ready set):
  - out_data <= granted channel data
  - out_chan <= granted index
  - out_valid <= 1
  - MODE 1: last <= granted index
- No accept and out_ready = 1: out_valid <= 0. out_data and out_chan keep their last value.
- Stall (out_valid = 1, out_ready = 0): out_data, out_chan and out_valid are frozen. All in_ready = 0. `last` is unchanged.
- `last` advances only on accept, never on grant alone.
- Implicit states: EMPTY (out_valid = 0) and FULL (out_valid = 1).
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept with out_ready = 1, or on stall.
  - FULL -> EMPTY on out_ready = 1 with no grant.

## Timing
- Reset, when rst_n = 0 at a rising edge: out_valid = 0, out_data = 0, out_chan = 0, last = CHANNELS-1 so channel 0 wins first. in_ready is 0 during reset.
- Reset mid-operation discards any held beat. The beat is not delivered.
- Latency: beat accepted at edge k appears on out_data/out_valid after edge k.
- Throughput: one beat per cycle while out_ready = 1.
- Simultaneous drain and accept in the same cycle: the new beat replaces the old with no bubble.
- MODE 1 fairness: with all CHANNELS valid and out_ready held 1, grants cycle 0,1,..,CHANNELS-1,0. Each channel waits at most CHANNELS-1 accepts.
- `sel` changing while FULL has no effect until the next load cycle.

## Test plan
- Reset, MODE 0, WIDTH 8, CHANNELS 4: hold rst_n = 0 two cycles with in_valid = 4'hF -> out_valid = 0, out_data = 8'h00, out_chan = 0, in_ready = 0. Release rst_n, sel = 2, ch2 = 8'hA5, out_ready = 1 -> next cycle out_data = 8'hA5, out_chan = 2, out_valid = 1.
- MODE 0 backpressure: hold out_ready = 0 while FULL with 8'h3C; change sel and data for 3 cycles -> out_data stays 8'h3C, in_ready = 0. Raise out_ready -> new channel's data loads that same edge with no bubble.
- MODE 0 out-of-range: CHANNELS = 3, sel = 3, all valid -> in_ready = 0. After draining, out_valid = 0 and out_data keeps its last value.
- MODE 1 rotation: all 4 channels valid, data = 8'h10+i, out_ready = 1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3.
- MODE 1 sparse plus stall: only ch1 and ch3 valid; stall 2 cycles after ch1 is accepted -> next grant is ch3, not ch1, and `last` does not move during the stall.
- Mid-operation reset: assert rst_n = 0 while FULL and stalled -> next cycle out_valid = 0. The first grant after reset (MODE 1, all valid) is ch0.

Source files
------------

// File: rtl/mux_arb_nto1_if.sv
// Handshake bundle for mux_arb_nto1: CHANNELS producer lanes in, one registered lane out.
// The master modport is the producer/consumer side and the slave modport is the mux.
interface mux_arb_nto1_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SELW     = $clog2(CHANNELS)
) ();
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SELW-1:0]           sel;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_arb_nto1.sv
// N-to-1 bus mux with one registered output slot; the channel is picked either by
// an external select or round-robin among valid channels.
module mux_arb_nto1 #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned MODE     = 0,
    parameter int unsigned SELW     = $clog2(CHANNELS)
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_arb_nto1_if.slave   bus
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [SELW-1:0]     chan_q, chan_d;
    logic [SELW-1:0]     last_q, last_d;

    logic [CHANNELS-1:0] grant;
    logic [SELW-1:0]     grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic                load;
    logic                accept;
    logic                found;

    assign load = (state_q == ST_EMPTY) | bus.out_ready;

    // Out-of-range sel simply matches no channel, so nothing is granted.
    always_comb begin
        grant = '0;
        found = 1'b0;
        if (MODE == 0) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (SELW'(i) == bus.sel) grant[i] = bus.in_valid[i];
            end
        end else begin
            for (int unsigned k = 1; k <= CHANNELS; k++) begin
                for (int unsigned i = 0; i < CHANNELS; i++) begin
                    if (!found && bus.in_valid[i] &&
                        i == (32'(last_q) + k) % CHANNELS) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                grant_idx  = SELW'(i);
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.in_ready = (rst_n && load) ? grant : '0;
    assign accept       = |bus.in_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        last_d  = last_q;
        if (accept) begin
            state_d = ST_FULL;
            data_d  = grant_data;
            chan_d  = grant_idx;
            if (MODE != 0) last_d = grant_idx;
        end else if (bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
            last_q  <= SELW'(CHANNELS - 1);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            last_q  <= last_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;
    assign bus.out_valid = (state_q == ST_FULL);
endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench for mux_arb_nto1: fixed select (4 and 3 channels) and round-robin.
module tb_mux_arb_nto1;
    logic clk = 1'b0;
    logic rst0, rst1, rst2;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mux_arb_nto1_if #(.WIDTH(8), .CHANNELS(4)) b0 ();
    mux_arb_nto1_if #(.WIDTH(8), .CHANNELS(3)) b1 ();
    mux_arb_nto1_if #(.WIDTH(8), .CHANNELS(4)) b2 ();

    mux_arb_nto1 #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u0 (.clk(clk), .rst_n(rst0), .bus(b0));
    mux_arb_nto1 #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u1 (.clk(clk), .rst_n(rst1), .bus(b1));
    mux_arb_nto1 #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u2 (.clk(clk), .rst_n(rst2), .bus(b2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b0;
        b0.in_valid = 4'hF; b0.sel = 2'd2; b0.out_ready = 1'b1;
        b0.in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        tick(); tick();
        checks++; if (b0.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", b0.out_valid); end
        checks++; if (b0.out_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", b0.out_data); end
        checks++; if (b0.out_chan !== 2'd0) begin failures++; $display("FAIL rst_chan got=%0d exp=0", b0.out_chan); end
        checks++; if (b0.in_ready !== 4'h0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0000", b0.in_ready); end
        rst0 = 1'b1;
        #1;
        checks++; if (b0.in_ready !== 4'b0100) begin failures++; $display("FAIL first_in_ready got=%b exp=0100", b0.in_ready); end
        tick();
        checks++; if (b0.out_data !== 8'hA5) begin failures++; $display("FAIL first_data got=%h exp=a5", b0.out_data); end
        checks++; if (b0.out_chan !== 2'd2) begin failures++; $display("FAIL first_chan got=%0d exp=2", b0.out_chan); end
        checks++; if (b0.out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b exp=1", b0.out_valid); end
    endtask

    task automatic test_backpressure();
        b0.sel = 2'd1; b0.in_data = {8'h44, 8'hA5, 8'h3C, 8'h11};
        tick();
        checks++; if (b0.out_data !== 8'h3C) begin failures++; $display("FAIL bp_load got=%h exp=3c", b0.out_data); end
        b0.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            b0.sel = 2'(j);
            b0.in_data = {8'(8'h80 + j), 8'(8'h90 + j), 8'(8'hA0 + j), 8'(8'hB0 + j)};
            #1;
            checks++; if (b0.in_ready !== 4'h0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0000", b0.in_ready); end
            tick();
            checks++; if (b0.out_data !== 8'h3C || b0.out_chan !== 2'd1 || b0.out_valid !== 1'b1)
                begin failures++; $display("FAIL bp_hold got=%h/%0d/%b exp=3c/1/1", b0.out_data, b0.out_chan, b0.out_valid); end
        end
        b0.sel = 2'd3; b0.in_data = {8'h7E, 8'h00, 8'h00, 8'h00}; b0.out_ready = 1'b1;
        #1;
        checks++; if (b0.in_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_ready got=%b exp=1000", b0.in_ready); end
        tick();
        checks++; if (b0.out_data !== 8'h7E || b0.out_chan !== 2'd3 || b0.out_valid !== 1'b1)
            begin failures++; $display("FAIL bp_no_bubble got=%h/%0d/%b exp=7e/3/1", b0.out_data, b0.out_chan, b0.out_valid); end
        b0.in_valid = 4'h0;
        tick();
        checks++; if (b0.out_valid !== 1'b0 || b0.out_data !== 8'h7E)
            begin failures++; $display("FAIL bp_drain got=%b/%h exp=0/7e", b0.out_valid, b0.out_data); end
    endtask

    task automatic test_out_of_range();
        rst1 = 1'b0;
        b1.in_valid = 3'b111; b1.sel = 2'd1; b1.out_ready = 1'b1;
        b1.in_data = {8'h33, 8'h5A, 8'h11};
        tick();
        rst1 = 1'b1;
        tick();
        checks++; if (b1.out_data !== 8'h5A || b1.out_valid !== 1'b1)
            begin failures++; $display("FAIL oor_load got=%h/%b exp=5a/1", b1.out_data, b1.out_valid); end
        b1.sel = 2'd3;
        #1;
        checks++; if (b1.in_ready !== 3'b000) begin failures++; $display("FAIL oor_in_ready got=%b exp=000", b1.in_ready); end
        tick();
        checks++; if (b1.out_valid !== 1'b0 || b1.out_data !== 8'h5A)
            begin failures++; $display("FAIL oor_drain got=%b/%h exp=0/5a", b1.out_valid, b1.out_data); end
        tick();
        checks++; if (b1.out_valid !== 1'b0 || b1.out_data !== 8'h5A)
            begin failures++; $display("FAIL oor_idle got=%b/%h exp=0/5a", b1.out_valid, b1.out_data); end
    endtask

    task automatic test_rotation();
        rst2 = 1'b0;
        b2.in_valid = 4'hF; b2.sel = 2'd0; b2.out_ready = 1'b1;
        b2.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        tick(); tick();
        checks++; if (b2.in_ready !== 4'h0) begin failures++; $display("FAIL rr_rst_ready got=%b exp=0000", b2.in_ready); end
        rst2 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (b2.out_chan !== 2'(k % 4) || b2.out_data !== 8'(8'h10 + k % 4) || b2.out_valid !== 1'b1)
                begin failures++; $display("FAIL rr_seq%0d got=%0d/%h exp=%0d/%h", k, b2.out_chan, b2.out_data, k % 4, 8'h10 + k % 4); end
        end
    endtask

    task automatic test_sparse_stall();
        b2.in_valid = 4'b1010;
        tick();
        checks++; if (b2.out_chan !== 2'd1 || b2.out_data !== 8'h11) begin failures++; $display("FAIL sp_first got=%0d/%h exp=1/11", b2.out_chan, b2.out_data); end
        b2.out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            #1;
            checks++; if (b2.in_ready !== 4'h0) begin failures++; $display("FAIL sp_stall_ready got=%b exp=0000", b2.in_ready); end
            tick();
            checks++; if (b2.out_chan !== 2'd1 || b2.out_valid !== 1'b1) begin failures++; $display("FAIL sp_stall_hold got=%0d/%b exp=1/1", b2.out_chan, b2.out_valid); end
        end
        b2.out_ready = 1'b1;
        #1;
        checks++; if (b2.in_ready !== 4'b1000) begin failures++; $display("FAIL sp_next_ready got=%b exp=1000", b2.in_ready); end
        tick();
        checks++; if (b2.out_chan !== 2'd3 || b2.out_data !== 8'h13) begin failures++; $display("FAIL sp_ch3 got=%0d/%h exp=3/13", b2.out_chan, b2.out_data); end
        tick();
        checks++; if (b2.out_chan !== 2'd1) begin failures++; $display("FAIL sp_wrap got=%0d exp=1", b2.out_chan); end
    endtask

    task automatic test_mid_reset();
        b2.in_valid = 4'hF; b2.out_ready = 1'b0;
        tick();
        checks++; if (b2.out_valid !== 1'b1) begin failures++; $display("FAIL mr_full got=%b exp=1", b2.out_valid); end
        rst2 = 1'b0;
        tick();
        checks++; if (b2.out_valid !== 1'b0 || b2.out_data !== 8'h00) begin failures++; $display("FAIL mr_cleared got=%b/%h exp=0/00", b2.out_valid, b2.out_data); end
        rst2 = 1'b1; b2.out_ready = 1'b1;
        #1;
        checks++; if (b2.in_ready !== 4'b0001) begin failures++; $display("FAIL mr_ready got=%b exp=0001", b2.in_ready); end
        tick();
        checks++; if (b2.out_chan !== 2'd0 || b2.out_data !== 8'h10) begin failures++; $display("FAIL mr_first got=%0d/%h exp=0/10", b2.out_chan, b2.out_data); end
    endtask

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        b0.in_data = '0; b0.in_valid = '0; b0.sel = '0; b0.out_ready = 1'b0;
        b1.in_data = '0; b1.in_valid = '0; b1.sel = '0; b1.out_ready = 1'b0;
        b2.in_data = '0; b2.in_valid = '0; b2.sel = '0; b2.out_ready = 1'b0;
        test_reset();
        test_backpressure();
        test_out_of_range();
        test_rotation();
        test_sparse_stall();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
